dcache_refill_ctrl: RTL and testbench
=====================================

DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 8, words per cache line; only 8 supported (32-byte line, index addr[11:5], word offset addr[4:2]).
REQ-002 clk input 1 clock; all state updates on rising edge.
REQ-003 rst input 1 synchronous, active-low reset.
REQ-004 cpu_req input 1, cpu_wr input 1, cpu_addr input 32: load/store request, sampled the same cycle it is presented to the tag array.
REQ-005 cpu_stall output 1: pipeline must hold its request while high.
REQ-006 tag_work input 1, tag_hit input 1, tag_valid input 1: tag-array status; hit/valid refer to the address presented one cycle earlier.
REQ-007 tag_wen output 1, tag_wdata output 21 ({valid, addr[31:12]}): tag write port.
REQ-008 mem_rd_req output 1, mem_rd_addr output 32, mem_rd_ack input 1: burst read request and acceptance.
REQ-009 mem_rvalid input 1, mem_rdata input 32, mem_rlast input 1: burst return beats.
REQ-010 dram_wen output 1, dram_index output 7, dram_offset output 3, dram_wdata output 32: data-RAM fill port.
REQ-011 miss_cnt output 32: read-miss count, present only under DCACHE_PERF_CNT_EN.

Function
REQ-012 States: INIT, IDLE, LOOKUP, MISS_REQ, REFILL, TAG_UPD, REPLAY.
REQ-013 INIT: cpu_stall=1; go to IDLE the cycle after tag_work is first seen high.
REQ-014 IDLE: cpu_req=1 captures cpu_addr/cpu_wr into req_addr/req_wr, then LOOKUP; no request stays in IDLE.
REQ-015 LOOKUP, tag_hit&tag_valid: hit; cpu_stall=0; a new cpu_req is captured back-to-back (stay LOOKUP), else IDLE.
REQ-016 LOOKUP, miss with req_wr=1: write-through, no allocate; cpu_stall=0, same next-state rule as REQ-015.
REQ-017 LOOKUP, miss with req_wr=0: cpu_stall=1 combinationally in that cycle; go to MISS_REQ.
REQ-018 MISS_REQ: mem_rd_req=1, mem_rd_addr={req_addr[31:5],5'b0} held stable until mem_rd_ack; on ack go to REFILL, word counter=0.
REQ-019 REFILL: each mem_rvalid beat drives dram_wen=1, dram_index=req_addr[11:5], dram_offset=counter, dram_wdata=mem_rdata, counter+1 (3-bit wrap).
REQ-020 REFILL ends on the beat where mem_rlast=1 or counter=7, whichever first; go to TAG_UPD; early mem_rlast leaves remaining words unwritten.
REQ-021 TAG_UPD: one cycle, tag_wen=1, tag_wdata={1'b1,req_addr[31:12]}; go to REPLAY.
REQ-022 REPLAY: re-present req_addr to the tag array for one cycle (cpu_stall=1); go to LOOKUP, which must now hit.
REQ-023 cpu_stall=1 in INIT, MISS_REQ, REFILL, TAG_UPD, REPLAY, and LOOKUP-read-miss; 0 otherwise.
REQ-024 mem_rvalid outside REFILL is ignored; mem_rd_ack outside MISS_REQ is ignored.
REQ-025 tag_wen never asserted outside TAG_UPD; dram_wen never outside REFILL.
REQ-026 Miss-to-unstall latency: 1 (MISS_REQ min) + beats + 1 (TAG_UPD) + 1 (REPLAY) + 1 (LOOKUP) cycles.

Reset
REQ-027 rst=0: state=INIT, counter=0, req_addr=0, req_wr=0, all request/write-enable outputs 0, cpu_stall=1, miss_cnt=0.
REQ-028 rst=0 mid-refill aborts immediately; no tag_wen is issued for the aborted line, and outstanding beats after reset are ignored until MISS_REQ.
REQ-029 tag_work dropping low in any state forces INIT on the next cycle.

Configuration
REQ-030 Macro DCACHE_PERF_CNT_EN defined: miss_cnt increments by 1 on each LOOKUP-read-miss, wraps at 2^32-1 to 0; undefined: port miss_cnt and its counter are absent, all other behaviour identical.

Verification
REQ-031 Reset then tag_work high after 128 cycles -> cpu_stall high through cycle 129, IDLE next cycle.
REQ-032 Read 0x0000_1040, tag_hit=1, valid=1 -> cpu_stall=0 in LOOKUP, no mem_rd_req.
REQ-033 Read miss 0x8000_2064, 8 beats 0xA0..0xA7, ack after 3 cycles -> mem_rd_addr=0x8000_2060, dram writes index 0x03 offsets 0..7, tag_wdata=0x1_80002, unstall after replay hit.
REQ-034 Write miss 0x0000_0100 -> cpu_stall=0, no mem_rd_req, no tag_wen.
REQ-035 rst low on 4th refill beat -> state INIT, no tag_wen, later beats ignored, miss_cnt=0.
REQ-036 With DCACHE_PERF_CNT_EN, 3 read misses and 2 hits -> miss_cnt=3.

Source files
------------

// File: rtl/dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_refill_ctrl
// Data-cache miss/refill controller. Looks up each CPU request in the tag
// array, lets hits and write misses (write-through, no allocate) through
// without stalling, and handles a read miss by fetching the 32-byte line as a
// memory burst into the data RAM. It then writes the tag and replays the
// lookup.
//
// Optional feature: define DCACHE_PERF_CNT_EN to add the o_miss_cnt port, a
// wrapping 32-bit count of read misses.
//
// Ports
//   clk, rst         clock; synchronous active-low reset
//   i_cpu_req/wr/addr  load/store request (i_cpu_addr also feeds the tag array)
//   o_cpu_stall      pipeline must hold its request while high
//   i_tag_work       tag array initialised and usable
//   i_tag_hit/valid  lookup result for the address presented last cycle
//   o_tag_wen/wdata  tag write port, wdata = {valid, addr[31:12]}
//   o_mem_rd_*       burst read request, line-aligned address, acceptance
//   i_mem_r*         burst return beats
//   o_dram_*         data-RAM fill port (index = addr[11:5], word offset)
//   o_miss_cnt       read-miss count (DCACHE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module dcache_refill_ctrl #(
  parameter int LINE_WORDS = 8  // only 8 supported: 32-byte line
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wr,
  input  logic [31:0] i_cpu_addr,
  output logic        o_cpu_stall,
  input  logic        i_tag_work,
  input  logic        i_tag_hit,
  input  logic        i_tag_valid,
  output logic        o_tag_wen,
  output logic [20:0] o_tag_wdata,
  output logic        o_mem_rd_req,
  output logic [31:0] o_mem_rd_addr,
  input  logic        i_mem_rd_ack,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rlast,
  output logic        o_dram_wen,
  output logic [6:0]  o_dram_index,
  output logic [2:0]  o_dram_offset,
  output logic [31:0] o_dram_wdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_TAG_UPD,
    S_REPLAY
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_req_addr;
  logic        r_req_wr;

  logic w_hit;
  logic w_read_miss;
  logic w_unused_addr;

  assign w_hit       = i_tag_hit && i_tag_valid;
  assign w_read_miss = (r_state == S_LOOKUP) && !w_hit && !r_req_wr;

  // Byte/word offset bits are kept with the request but only the line
  // address is consumed here.
  assign w_unused_addr = ^r_req_addr[4:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would make results order-dependent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_INIT;
      r_cnt      <= 3'd0;
      r_req_addr <= 32'd0;
      r_req_wr   <= 1'b0;
    end else if (!i_tag_work) begin
      // Tag array lost (or never reached) its initialised state.
      r_state <= S_INIT;
    end else begin
      unique case (r_state)
        S_INIT: r_state <= S_IDLE;
        S_IDLE: begin
          if (i_cpu_req) begin
            r_req_addr <= i_cpu_addr;
            r_req_wr   <= i_cpu_wr;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_read_miss) begin
            r_state <= S_MISS_REQ;
          end else if (i_cpu_req) begin
            // Back-to-back request: its lookup result arrives next cycle.
            r_req_addr <= i_cpu_addr;
            r_req_wr   <= i_cpu_wr;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MISS_REQ: begin
          if (i_mem_rd_ack) begin
            r_cnt   <= 3'd0;
            r_state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (i_mem_rvalid) begin
            r_cnt <= r_cnt + 3'd1;
            // An early rlast leaves the rest of the line unwritten.
            if (i_mem_rlast || (r_cnt == LAST_WORD)) r_state <= S_TAG_UPD;
          end
        end
        S_TAG_UPD: r_state <= S_REPLAY;
        S_REPLAY:  r_state <= S_LOOKUP;
        default:   r_state <= S_INIT;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                          r_miss_cnt <= 32'd0;
    else if (i_tag_work && w_read_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
  end

  assign o_miss_cnt = r_miss_cnt;
`endif

  // Outputs decode the registered state. Stall in LOOKUP depends on this
  // cycle's tag result, and the fill strobe follows each returning beat.
  // Everything is qualified by rst so a reset aborts a refill in the cycle it
  // is applied rather than one edge later.
  assign o_cpu_stall   = !rst || !((r_state == S_IDLE) ||
                                   ((r_state == S_LOOKUP) && !w_read_miss));
  assign o_mem_rd_req  = rst && (r_state == S_MISS_REQ);
  assign o_mem_rd_addr = {r_req_addr[31:5], 5'b0};
  assign o_tag_wen     = rst && (r_state == S_TAG_UPD);
  assign o_tag_wdata   = {1'b1, r_req_addr[31:12]};
  assign o_dram_wen    = rst && (r_state == S_REFILL) && i_mem_rvalid;
  assign o_dram_index  = r_req_addr[11:5];
  assign o_dram_offset = r_cnt;
  assign o_dram_wdata  = i_mem_rdata;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_refill_ctrl
// Directed scenarios with literal expectations, followed by randomized
// traffic. A transaction-level model of the controller predicts every output
// on every cycle. Define DCACHE_PERF_CNT_EN to also check o_miss_cnt.
// ---------------------------------------------------------------------------
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr;
  logic        tag_work, tag_hit, tag_valid;
  logic        mem_rd_ack, mem_rvalid, mem_rlast;
  logic [31:0] mem_rdata;

  logic        cpu_stall, tag_wen, mem_rd_req, dram_wen;
  logic [20:0] tag_wdata;
  logic [31:0] mem_rd_addr, dram_wdata;
  logic [6:0]  dram_index;
  logic [2:0]  dram_offset;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_refill_ctrl #(.LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr),
    .o_cpu_stall(cpu_stall),
    .i_tag_work(tag_work), .i_tag_hit(tag_hit), .i_tag_valid(tag_valid),
    .o_tag_wen(tag_wen), .o_tag_wdata(tag_wdata),
    .o_mem_rd_req(mem_rd_req), .o_mem_rd_addr(mem_rd_addr), .i_mem_rd_ack(mem_rd_ack),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .i_mem_rlast(mem_rlast),
    .o_dram_wen(dram_wen), .o_dram_index(dram_index), .o_dram_offset(dram_offset),
    .o_dram_wdata(dram_wdata)
`ifdef DCACHE_PERF_CNT_EN
    , .o_miss_cnt(miss_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: where the controller is in handling the current request.
  localparam int P_NONE = 0, P_ACK = 1, P_BEATS = 2, P_TAGW = 3, P_REPLAY = 4;
  bit          m_ready;   // tag array seen working since last reset/drop
  bit          m_look;    // a captured request awaits its tag result
  int          m_phase;   // progress of a read-miss line fill
  int          m_beat;    // words written so far in this fill
  logic [31:0] m_addr;
  bit          m_wr;
  logic [31:0] m_cnt;

  // Outputs sampled mid-cycle by step(), used for literal checks.
  logic        s_stall, s_rdreq, s_twen, s_dwen;
  logic [31:0] s_rdaddr, s_dwdata, s_miss;
  logic [20:0] s_twdata;
  logic [6:0]  s_didx;
  logic [2:0]  s_doff;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_look = 0; m_phase = P_NONE; m_beat = 0;
    m_addr = '0; m_wr = 0; m_cnt = '0;
  endtask

  // One clock cycle: compare outputs against the model on the falling edge,
  // then advance the model with the inputs that the rising edge sees.
  task automatic step();
    bit exp_stall, exp_rdreq, exp_twen, exp_dwen, read_miss;
    @(negedge clk);
    read_miss = m_look && !(tag_hit && tag_valid) && !m_wr;
    exp_stall = !rst || !m_ready || (m_phase != P_NONE) || read_miss;
    exp_rdreq = rst && (m_phase == P_ACK);
    exp_twen  = rst && (m_phase == P_TAGW);
    exp_dwen  = rst && (m_phase == P_BEATS) && mem_rvalid;

    s_stall = cpu_stall; s_rdreq = mem_rd_req; s_rdaddr = mem_rd_addr;
    s_twen = tag_wen; s_twdata = tag_wdata; s_dwen = dram_wen;
    s_didx = dram_index; s_doff = dram_offset; s_dwdata = dram_wdata;
`ifdef DCACHE_PERF_CNT_EN
    s_miss = miss_cnt;
    check("miss_cnt", 64'(s_miss), 64'(m_cnt));
`else
    s_miss = '0;
`endif
    check("cpu_stall", 64'(s_stall), 64'(exp_stall));
    check("mem_rd_req", 64'(s_rdreq), 64'(exp_rdreq));
    check("tag_wen", 64'(s_twen), 64'(exp_twen));
    check("dram_wen", 64'(s_dwen), 64'(exp_dwen));
    if (exp_rdreq) check("mem_rd_addr", 64'(s_rdaddr), 64'(m_addr & 32'hFFFF_FFE0));
    if (exp_twen)  check("tag_wdata", 64'(s_twdata), 64'({1'b1, m_addr[31:12]}));
    if (exp_dwen) begin
      check("dram_index", 64'(s_didx), 64'((m_addr >> 5) % 128));
      check("dram_offset", 64'(s_doff), 64'(m_beat));
      check("dram_wdata", 64'(s_dwdata), 64'(mem_rdata));
    end

    @(posedge clk);
    if (!rst) model_reset();
    else if (!tag_work) begin
      m_ready = 0; m_look = 0; m_phase = P_NONE;
    end else if (!m_ready) m_ready = 1;
    else begin
      case (m_phase)
        P_ACK:    if (mem_rd_ack) begin m_phase = P_BEATS; m_beat = 0; end
        P_BEATS:  if (mem_rvalid) begin
                    if (mem_rlast || m_beat == 7) m_phase = P_TAGW;
                    m_beat = (m_beat + 1) % 8;
                  end
        P_TAGW:   m_phase = P_REPLAY;
        P_REPLAY: begin m_phase = P_NONE; m_look = 1; end
        default: begin
          if (read_miss) begin
            m_look = 0; m_phase = P_ACK; m_cnt = m_cnt + 1;
          end else if (cpu_req) begin
            m_addr = cpu_addr; m_wr = cpu_wr; m_look = 1;
          end else m_look = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic quiet();
    cpu_req = 0; cpu_wr = 0; mem_rd_ack = 0; mem_rvalid = 0; mem_rlast = 0;
  endtask

  // Full read: hit, or miss with immediate ack and nbeats beats (rlast only
  // when the burst is shorter than a line), then the replayed lookup hits.
  task automatic do_read(input logic [31:0] addr, input bit hit, input int nbeats);
    quiet();
    cpu_req = 1; cpu_addr = addr; step();
    cpu_req = 0; tag_hit = hit; tag_valid = 1; step();
    if (!hit) begin
      mem_rd_ack = 1; step(); mem_rd_ack = 0;
      for (int i = 0; i < nbeats; i++) begin
        mem_rvalid = 1; mem_rdata = $urandom;
        mem_rlast = (i == nbeats - 1) && (nbeats < 8);
        step();
      end
      mem_rvalid = 0; mem_rlast = 0;
      step(); step();
      tag_hit = 1; step();
    end
  endtask

  initial begin
    rst = 0; tag_work = 0; tag_hit = 0; tag_valid = 0;
    cpu_addr = '0; mem_rdata = '0;
    quiet();
    @(posedge clk); #1;
    model_reset();

    // Reset state
    repeat (2) step();
    check("reset stall", 64'(s_stall), 64'd1);
    check("reset rd_req", 64'(s_rdreq), 64'd0);
    check("reset miss_cnt", 64'(s_miss), 64'd0);

    // Tag array comes up after 128 cycles
    rst = 1;
    repeat (128) step();
    check("init stall", 64'(s_stall), 64'd1);
    tag_work = 1; step();
    check("init stall cycle 129", 64'(s_stall), 64'd1);
    step();
    check("idle unstalled", 64'(s_stall), 64'd0);

    // Read hit
    cpu_req = 1; cpu_addr = 32'h0000_1040; step();
    cpu_req = 0; tag_hit = 1; tag_valid = 1; step();
    check("hit stall", 64'(s_stall), 64'd0);
    check("hit rd_req", 64'(s_rdreq), 64'd0);

    // Read miss with 8-beat burst, ack after 3 cycles
    cpu_req = 1; cpu_addr = 32'h8000_2064; step();
    cpu_req = 0; tag_hit = 0; step();
    check("miss stall", 64'(s_stall), 64'd1);
    repeat (3) step();
    check("miss rd_req", 64'(s_rdreq), 64'd1);
    check("miss rd_addr", 64'(s_rdaddr), 64'h8000_2060);
    mem_rd_ack = 1; step(); mem_rd_ack = 0;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid = 1; mem_rdata = 32'hA0 + 32'(i); mem_rlast = (i == 7);
      step();
      check("fill wen", 64'(s_dwen), 64'd1);
      check("fill index", 64'(s_didx), 64'h03);
      check("fill offset", 64'(s_doff), 64'(i));
      check("fill data", 64'(s_dwdata), 64'hA0 + 64'(i));
    end
    mem_rvalid = 0; mem_rlast = 0;
    step();
    check("tag wen", 64'(s_twen), 64'd1);
    check("tag wdata", 64'(s_twdata), 64'h1_80002);
    step();
    check("replay stall", 64'(s_stall), 64'd1);
    tag_hit = 1; step();
    check("replay hit unstall", 64'(s_stall), 64'd0);

    // Write miss: no allocate
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h0000_0100; step();
    cpu_req = 0; cpu_wr = 0; tag_hit = 0; step();
    check("wmiss stall", 64'(s_stall), 64'd0);
    check("wmiss rd_req", 64'(s_rdreq), 64'd0);
    step();
    check("wmiss tag_wen", 64'(s_twen), 64'd0);
    check("wmiss rd_req idle", 64'(s_rdreq), 64'd0);

    // Reset during the 4th refill beat
    rst = 0; step(); rst = 1; step();
    cpu_req = 1; cpu_addr = 32'h4000_0A20; step();
    cpu_req = 0; tag_hit = 0; step();
    mem_rd_ack = 1; step(); mem_rd_ack = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1; mem_rdata = $urandom; step();
    end
    rst = 0; step();
    check("abort wen", 64'(s_dwen), 64'd0);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = 1; mem_rlast = (i == 4); step();
      check("abort beat ignored", 64'(s_dwen), 64'd0);
      check("abort no tag_wen", 64'(s_twen), 64'd0);
    end
    quiet();
    check("abort miss_cnt", 64'(s_miss), 64'd0);

    // Three read misses (short, full, short) and two hits
    do_read(32'h1234_5678, 0, 3);
    do_read(32'h0000_0040, 1, 0);
    do_read(32'hCAFE_01E0, 0, 8);
    do_read(32'h0000_1040, 1, 0);
    do_read(32'h7FFF_FFFC, 0, 1);
    step();
`ifdef DCACHE_PERF_CNT_EN
    check("miss_cnt three", 64'(s_miss), 64'd3);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 299) != 0);
      tag_work   = ($urandom_range(0, 149) != 0);
      cpu_req    = ($urandom_range(0, 1) == 1);
      cpu_wr     = ($urandom_range(0, 2) == 0);
      cpu_addr   = $urandom;
      tag_hit    = ($urandom_range(0, 1) == 1);
      tag_valid  = ($urandom_range(0, 4) != 0);
      mem_rd_ack = ($urandom_range(0, 2) == 0);
      mem_rvalid = ($urandom_range(0, 4) < 3);
      mem_rlast  = ($urandom_range(0, 6) == 0);
      mem_rdata  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
